spi_master: RTL and testbench

- SPI initiator (mode 0, MSB first) that drives the serial side of the team's serial-in/parallel-out shift-register peripherals.
- On a start request it frames one word with active-low chip select and generates sclk from the system clock.
- Shifts txData out on mosi and captures miso into rxData.
- Sits between the test/control FSM and the SPI pins; its sclk feeds the peripheral's edge-detected shift clock.

---
 rtl/spi_master.sv | 176 +++++++++++++++++
 tb/tb_spi_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI initiator, mode 0 (sclk idle low, sample on rising edge), MSB first.
// Frames one word per accepted start with an active-low chip select and
// derives sclk from clk with a programmable half-period.
module spi_master #(
    parameter int width  = 8,   // bits per transaction, >= 2
    parameter int clkdiv = 4    // sclk half-period in clk cycles, >= 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [width-1:0] txData,
    output logic [width-1:0] rxData,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             cs,
    output logic             mosi,
    input  logic             miso
);

    localparam int DIV_W = (clkdiv > 1) ? $clog2(clkdiv) : 1;
    localparam int CNT_W = $clog2(width + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic [width-1:0]   tx_q, tx_d;
    logic [width-1:0]   rx_q, rx_d;
    logic [width-1:0]   rx_data_q, rx_data_d;
    logic               sclk_q, sclk_d;
    logic               cs_q, cs_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               phase_end;
    logic [CNT_W-1:0]   bit_inc;
    logic               last_bit;

    // Every timed phase (SETUP/HIGH/LOW/HOLD) lasts exactly clkdiv cycles.
    assign phase_end = (div_q == DIV_W'(clkdiv - 1));
    assign bit_inc   = bit_q + CNT_W'(1);
    assign last_bit  = (bit_inc == CNT_W'(width));

    assign rxData = rx_data_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign sclk   = sclk_q;
    assign cs     = cs_q;
    assign mosi   = tx_q[width-1];

    // State register and all datapath flops; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and registered-output logic; sclk rises sample miso, falls advance mosi.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    tx_d    = txData;
                    bit_d   = '0;
                    div_d   = '0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            SETUP: begin
                if (phase_end) begin
                    state_d = HIGH;
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[width-2:0], miso};
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            HIGH: begin
                if (phase_end) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    bit_d  = bit_inc;
                    if (last_bit) begin
                        // Last bit stays on mosi through the hold phase.
                        state_d = HOLD;
                    end else begin
                        state_d = LOW;
                        tx_d    = {tx_q[width-2:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            LOW: begin
                if (phase_end) begin
                    state_d = HIGH;
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[width-2:0], miso};
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            HOLD: begin
                if (phase_end) begin
                    state_d   = FINISH;
                    div_d     = '0;
                    cs_d      = 1'b1;
                    done_d    = 1'b1;
                    rx_data_d = rx_q;
                    tx_d      = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            FINISH: begin
                // start is ignored here; busy drops as we return to IDLE.
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master: loopback, shift-register
// peripheral, edge timing, back-to-back starts, mid-transaction reset and a
// 16-bit / clkdiv=2 instance.
module tb_spi_master;

    logic        clk;
    logic        rst_n;

    // Instance A: width=8, clkdiv=4
    logic        startA;
    logic [7:0]  txA;
    logic [7:0]  rxA;
    logic        busyA, doneA, sclkA, csA, mosiA, misoA;

    // Instance B: width=16, clkdiv=2, loopback
    logic        startB;
    logic [15:0] txB;
    logic [15:0] rxB;
    logic        busyB, doneB, sclkB, csB, mosiB, misoB;

    // Peripheral model (edge-detected shift clock, serial-in/parallel-out)
    logic        loop_sel;
    logic [7:0]  p_reg;
    logic [7:0]  p_init;
    logic        p_load;
    logic        p_cap;
    logic        p_sclk_prev;

    int vectors;
    int miscompares;

    spi_master #(.width(8), .clkdiv(4)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (startA),
        .txData (txA),
        .rxData (rxA),
        .busy   (busyA),
        .done   (doneA),
        .sclk   (sclkA),
        .cs     (csA),
        .mosi   (mosiA),
        .miso   (misoA)
    );

    spi_master #(.width(16), .clkdiv(2)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (startB),
        .txData (txB),
        .rxData (rxB),
        .busy   (busyB),
        .done   (doneB),
        .sclk   (sclkB),
        .cs     (csB),
        .mosi   (mosiB),
        .miso   (misoB)
    );

    assign misoA = loop_sel ? mosiA : p_reg[7];
    assign misoB = mosiB;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral: captures mosi on a detected sclk rise, shifts on a detected fall.
    always @(posedge clk) begin
        if (p_load) begin
            p_reg <= p_init;
        end else begin
            if (!p_sclk_prev && sclkA && !csA) p_cap <= mosiA;
            if (p_sclk_prev && !sclkA && !csA) p_reg <= {p_reg[6:0], p_cap};
        end
        p_sclk_prev <= sclkA;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction on instance A with edge-timing checks; E0 is the accepting edge.
    task automatic run_a(input logic [7:0] tx, output logic [7:0] rx_out, output logic [7:0] mosi_seq);
        int   n;
        int   rises;
        int   falls;
        logic prev_sclk;
        bit   cs_ok;
        txA    = tx;
        startA = 1'b1;
        tick();
        startA = 1'b0;
        txA    = ~tx;   // later changes must not affect this transaction
        n = 0;
        check("cs_fall", csA, 1'b0);
        check("busy_rise", busyA, 1'b1);
        check("mosi_first", mosiA, tx[7]);
        prev_sclk = sclkA;
        rises = 0;
        falls = 0;
        cs_ok = 1'b1;
        mosi_seq = 8'h00;
        while (doneA !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (!prev_sclk && sclkA) begin
                check("rise_time", n, 4 + 8 * rises);
                mosi_seq = {mosi_seq[6:0], mosiA};
                rises++;
            end
            if (prev_sclk && !sclkA) begin
                check("fall_time", n, 8 + 8 * falls);
                falls++;
            end
            if (doneA !== 1'b1 && csA !== 1'b0) cs_ok = 1'b0;
            prev_sclk = sclkA;
        end
        check("done_time", n, 68);
        check("cs_rise_at_done", csA, 1'b1);
        check("mosi_at_done", mosiA, 1'b0);
        check("busy_at_done", busyA, 1'b1);
        check("rise_count", rises, 8);
        check("fall_count", falls, 8);
        check("cs_low_throughout", cs_ok, 1'b1);
        rx_out = rxA;
        $display("txn A tx=%h rx=%h mosi_seq=%h cycles=%0d", tx, rxA, mosi_seq, n);
        tick();
        check("done_width", doneA, 1'b0);
        check("busy_after_done", busyA, 1'b0);
        check("rx_held", rxA, rx_out);
    endtask

    initial begin : stim
        logic [7:0] rx_v;
        logic [7:0] seq_v;
        logic [7:0] expq[$];
        logic [7:0] exp_v;
        int         dones;
        int         cs_hi;
        bit         seen_low;
        logic       prev_done;
        int         n;
        int         rises;
        logic       prev_s;

        vectors     = 0;
        miscompares = 0;
        rst_n    = 1'b0;
        startA   = 1'b0;
        txA      = 8'h00;
        startB   = 1'b0;
        txB      = 16'h0000;
        loop_sel = 1'b1;
        p_load   = 1'b0;
        p_init   = 8'h00;

        // Reset values
        repeat (3) tick();
        check("rst_cs", csA, 1'b1);
        check("rst_sclk", sclkA, 1'b0);
        check("rst_mosi", mosiA, 1'b0);
        check("rst_busy", busyA, 1'b0);
        check("rst_done", doneA, 1'b0);
        check("rst_rx", rxA, 8'h00);
        rst_n = 1'b1;
        repeat (2) tick();

        // Loopback 0xA5
        loop_sel = 1'b1;
        run_a(8'hA5, rx_v, seq_v);
        check("loop_mosi_seq", seq_v, 8'hA5);
        check("loop_rx", rx_v, 8'hA5);

        // Shift-register peripheral preloaded with 0x3C, master sends 0xC3
        p_init = 8'h3C;
        p_load = 1'b1;
        tick();
        p_load = 1'b0;
        loop_sel = 1'b0;
        run_a(8'hC3, rx_v, seq_v);
        check("periph_master_rx", rx_v, 8'h3C);
        check("periph_contents", p_reg, 8'hC3);
        check("periph_mosi_seq", seq_v, 8'hC3);
        loop_sel = 1'b1;

        // Reset at cycle 30 of a transaction
        txA    = 8'hA5;
        startA = 1'b1;
        tick();
        startA = 1'b0;
        repeat (30) tick();
        check("pre_rst_sclk_high", sclkA, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_cs", csA, 1'b1);
        check("midrst_sclk", sclkA, 1'b0);
        check("midrst_busy", busyA, 1'b0);
        check("midrst_rx", rxA, 8'h00);
        check("midrst_mosi", mosiA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_done", doneA, 1'b0);
        end
        rst_n = 1'b1;
        tick();
        check("post_rst_idle_done", doneA, 1'b0);
        run_a(8'h5A, rx_v, seq_v);
        check("post_rst_rx", rx_v, 8'h5A);

        // start held for 200 cycles; txData 0xFF then 0x00
        dones     = 0;
        cs_hi     = 0;
        seen_low  = 1'b0;
        prev_done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            startA = (i < 200);
            txA    = (i < 100) ? 8'hFF : 8'h00;
            if (startA && busyA === 1'b0) expq.push_back(txA);
            tick();
            if (doneA === 1'b1) begin
                dones++;
                check("b2b_pending", (expq.size() > 0), 1'b1);
                if (expq.size() > 0) begin
                    exp_v = expq.pop_front();
                    check("b2b_rx", rxA, exp_v);
                    $display("txn A b2b rx=%h expected=%h", rxA, exp_v);
                end
            end
            if (prev_done === 1'b1) check("b2b_done_width", doneA, 1'b0);
            if (csA === 1'b1) begin
                cs_hi++;
            end else begin
                if (seen_low && cs_hi > 0) check("b2b_cs_gap", cs_hi, 2);
                seen_low = 1'b1;
                cs_hi    = 0;
            end
            prev_done = doneA;
        end
        startA = 1'b0;
        check("b2b_done_count", dones, 3);
        check("b2b_idle", busyA, 1'b0);

        // Instance B: width=16, clkdiv=2, loopback 0x8001
        txB    = 16'h8001;
        startB = 1'b1;
        tick();
        startB = 1'b0;
        txB    = 16'h0000;
        n      = 0;
        rises  = 0;
        prev_s = sclkB;
        while (doneB !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (!prev_s && sclkB) rises++;
            prev_s = sclkB;
        end
        check("b_done_time", n, 66);
        check("b_rx", rxB, 16'h8001);
        check("b_rise_count", rises, 16);
        check("b_cs_at_done", csB, 1'b1);
        $display("txn B tx=8001 rx=%h cycles=%0d", rxB, n);
        tick();
        check("b_busy_after", busyB, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
